periph_channel: RTL and testbench
=================================

PERIPH_CHANNEL -- requirements
Module: periph_channel

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning peripheral address field width in bits.
REQ-002 SHALL have parameter PKT_W, default 32, meaning USB packet width in bits.
REQ-003 SHALL have parameter ADDRESS, default 0, width ADDR_W, meaning this channel's address.
REQ-004 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries; must be a power of two, at least 2.
REQ-005 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries; must be a power of two, at least 2.
REQ-006 SHALL have parameter RX_AF_THRESH, default 12, meaning RX almost-full occupancy threshold; range 1 to RX_DEPTH.
REQ-007 SHALL have parameter READY_CYCLES, default 63, meaning cycles after reset release before the channel is usable.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-009 SHALL have ports: tx_data in PKT_W host packet; tx_valid in 1 packet strobe; tx_full out 1 TX FIFO full.
REQ-010 SHALL have ports: core_tx_data out PKT_W-ADDR_W head payload; core_tx_valid out 1 head valid; core_tx_read in 1 pop.
REQ-011 SHALL have ports: core_rx_data in PKT_W-ADDR_W payload; core_rx_valid in 1 push; core_rx_full out 1 RX FIFO full.
REQ-012 SHALL have ports: rx_data out PKT_W stamped packet; rx_read in 1 pop; rx_empty out 1; rx_almost_full out 1; rx_full out 1.
REQ-013 SHALL have ports: drop_count out 8 count of dropped writes; ready out 1 channel usable.

Function
REQ-014 SHALL accept a TX write when tx_valid=1, tx_data[PKT_W-1:PKT_W-ADDR_W]==ADDRESS, ready=1 and tx_full=0; the stored entry is the low PKT_W-ADDR_W bits of tx_data.
REQ-015 SHALL ignore a tx_valid packet with a non-matching address, with no drop_count change.
REQ-016 SHALL treat an address-matching tx_valid with tx_full=1 or ready=0 as dropped.
REQ-017 SHALL run the TX FIFO first-word-fall-through: core_tx_valid=!empty; core_tx_data=head combinationally; core_tx_read with core_tx_valid=1 pops at the clock edge; core_tx_read while empty is ignored.
REQ-018 SHALL accept a core RX write when core_rx_valid=1, core_rx_full=0 and ready=1; otherwise a core_rx_valid is dropped.
REQ-019 SHALL run the RX FIFO first-word-fall-through: rx_empty=!non-empty; rx_data={ADDRESS, head}; rx_read with rx_empty=0 pops; rx_read while empty or while ready=0 is ignored.
REQ-020 SHALL keep occupancy counters of clog2(DEPTH)+1 bits per FIFO; full when the count equals DEPTH, empty when it equals 0; pointers wrap modulo DEPTH.
REQ-021 SHALL, on a simultaneous push and pop of a non-empty, non-full FIFO, perform both and leave the count unchanged.
REQ-022 SHALL block a push to a full FIFO even when a pop occurs in the same cycle.
REQ-023 SHALL ignore a pop of an empty FIFO in a cycle with a push; the pushed word is visible the next cycle.
REQ-024 SHALL drive rx_almost_full=1 when RX occupancy >= RX_AF_THRESH; all status flags are registered-count derived and valid the cycle after the update.
REQ-025 SHALL increment drop_count by 1 per dropped event, saturating at 255; it SHALL increment by 2 (saturating) when a TX drop and an RX drop coincide.
REQ-026 SHALL implement the ready counter counting from 0 after reset release, saturating at READY_CYCLES; ready=1 only when the count equals READY_CYCLES.
REQ-027 SHALL use no vendor FIFO IP; storage is inferred register/RAM arrays with synchronous writes.

Reset
REQ-028 SHALL, on rst assertion at any time, asynchronously clear both FIFO pointers and counts, drop_count and the ready counter, discarding in-flight data.
REQ-029 SHALL drive these outputs during and after reset: tx_full=0, core_tx_valid=0, core_rx_full=0, rx_empty=1, rx_almost_full=0, rx_full=0, drop_count=0, ready=0.
REQ-030 SHALL not reset the storage arrays; their contents are don't-care while the FIFO is empty.

Verification
REQ-031 SHALL cover: release reset, hold tx_valid with a matching address -> ready rises exactly READY_CYCLES cycles after release; the earlier writes are dropped and drop_count equals the number of those writes.
REQ-032 SHALL cover: after ready, write 16 matching packets with defaults -> tx_full=1; a 17th write gives drop_count+1; the 16 words pop in order on core_tx_data.
REQ-033 SHALL cover: with ADDRESS=3, send a packet with address 5 -> no write, core_tx_valid stays 0, drop_count unchanged.
REQ-034 SHALL cover: core pushes 12 words -> rx_almost_full=1 at count 12; rx_data[31:29]=3'd3 on every pop; 16 words give rx_full=1.
REQ-035 SHALL cover: simultaneous push and pop at count 8, then push and pop when empty -> count stays 8, then count becomes 1 with the pushed word at the head.
REQ-036 SHALL cover: assert rst mid-transfer with both FIFOs half full -> all flags return to their reset values immediately, drop_count=0, and ready reasserts after READY_CYCLES.

Source files
------------

// File: rtl/periph_channel.sv
// periph_channel: address-filtered host/core packet channel with FWFT TX and RX FIFOs,
// a saturating drop counter and a post-reset ready delay.
module periph_channel #(
  parameter int ADDR_W = 3,
  parameter int PKT_W = 32,
  parameter logic [ADDR_W-1:0] ADDRESS = '0,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int RX_AF_THRESH = 12,
  parameter int READY_CYCLES = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PKT_W-1:0]        tx_data,
  input  logic                    tx_valid,
  output logic                    tx_full,
  output logic [PKT_W-ADDR_W-1:0] core_tx_data,
  output logic                    core_tx_valid,
  input  logic                    core_tx_read,
  input  logic [PKT_W-ADDR_W-1:0] core_rx_data,
  input  logic                    core_rx_valid,
  output logic                    core_rx_full,
  output logic [PKT_W-1:0]        rx_data,
  input  logic                    rx_read,
  output logic                    rx_empty,
  output logic                    rx_almost_full,
  output logic                    rx_full,
  output logic [7:0]              drop_count,
  output logic                    ready
);
  localparam int PW = PKT_W - ADDR_W;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RDW = $clog2(READY_CYCLES + 2);
  localparam logic [TAW:0] TX_N = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_N = RX_DEPTH[RAW:0];
  localparam logic [RAW:0] RX_AF = RX_AF_THRESH[RAW:0];
  localparam logic [RDW-1:0] RDY_N = READY_CYCLES[RDW-1:0];

  logic [PW-1:0] tx_mem [TX_DEPTH];
  logic [PW-1:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0] tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0] rx_cnt_q, rx_cnt_d;
  logic [RDW-1:0] rdy_q, rdy_d;
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;
  logic tx_hit, tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_drop;

  assign tx_full = tx_cnt_q == TX_N;
  assign core_tx_valid = tx_cnt_q != '0;
  assign core_tx_data = tx_mem[tx_rp_q];
  assign core_rx_full = rx_cnt_q == RX_N;
  assign rx_full = core_rx_full;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_almost_full = rx_cnt_q >= RX_AF;
  assign rx_data = {ADDRESS, rx_mem[rx_rp_q]};
  assign drop_count = drop_q;
  assign ready = rdy_q == RDY_N;

  // Pushes are gated by registered full flags, so a same-cycle pop never frees room for a push.
  always_comb begin
    tx_hit = tx_valid && tx_data[PKT_W-1 -: ADDR_W] == ADDRESS;
    tx_push = tx_hit && ready && !tx_full;
    tx_drop = tx_hit && !tx_push;
    tx_pop = core_tx_read && core_tx_valid;
    rx_push = core_rx_valid && ready && !core_rx_full;
    rx_drop = core_rx_valid && !rx_push;
    rx_pop = rx_read && !rx_empty && ready;
    tx_wp_d = tx_wp_q + TAW'(tx_push);
    tx_rp_d = tx_rp_q + TAW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    rx_wp_d = rx_wp_q + RAW'(rx_push);
    rx_rp_d = rx_rp_q + RAW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    drop_sum = {1'b0, drop_q} + 9'(tx_drop) + 9'(rx_drop);
    drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    rdy_d = ready ? rdy_q : rdy_q + RDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      tx_cnt_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      rx_cnt_q <= '0;
      drop_q <= '0;
      rdy_q <= '0;
    end else begin
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      drop_q <= drop_d;
      rdy_q <= rdy_d;
    end
  end

  // Storage is left unreset; its contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data[PW-1:0];
    if (rx_push) rx_mem[rx_wp_q] <= core_rx_data;
  end
endmodule

// File: tb/tb_periph_channel.sv
// tb_periph_channel: directed checks of periph_channel with ADDRESS=3 and default depths.
module tb_periph_channel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_full;
  logic [28:0] core_tx_data;
  logic core_tx_valid;
  logic core_tx_read = 1'b0;
  logic [28:0] core_rx_data = '0;
  logic core_rx_valid = 1'b0;
  logic core_rx_full;
  logic [31:0] rx_data;
  logic rx_read = 1'b0;
  logic rx_empty, rx_almost_full, rx_full, ready;
  logic [7:0] drop_count;
  int n_cmp = 0;
  int n_err = 0;

  periph_channel #(.ADDRESS(3'd3)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_full(tx_full),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid), .core_tx_read(core_tx_read),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid), .core_rx_full(core_rx_full),
    .rx_data(rx_data), .rx_read(rx_read), .rx_empty(rx_empty), .rx_almost_full(rx_almost_full),
    .rx_full(rx_full), .drop_count(drop_count), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] flags();
    return {tx_full, core_tx_valid, core_rx_full, rx_empty, rx_almost_full, rx_full, ready};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_flags", 64'(flags()), 64'(7'b0001000));
    chk("reset_drop", 64'(drop_count), 64'd0);
    // ready delay with matching writes held from release
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = {3'd3, 29'h1};
    repeat (62) step();
    chk("ready_early", 64'(ready), 64'd0);
    step();
    chk("ready_at_63", 64'(ready), 64'd1);
    tx_valid = 1'b0;
    chk("drop_before_ready", 64'(drop_count), 64'd63);
    chk("tx_empty_after_drops", 64'(core_tx_valid), 64'd0);
    // fill TX
    for (int i = 0; i < 16; i++) begin
      tx_data = {3'd3, 29'(100 + i)};
      tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    chk("tx_full", 64'(tx_full), 64'd1);
    tx_data = {3'd3, 29'd999};
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("tx_overflow_drop", 64'(drop_count), 64'd64);
    core_tx_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tx_pop_%0d", i), 64'(core_tx_data), 64'(29'(100 + i)));
      step();
    end
    chk("tx_drained", 64'(core_tx_valid), 64'd0);
    step();
    core_tx_read = 1'b0;
    chk("tx_pop_empty_ignored", 64'(tx_full), 64'd0);
    // non-matching address
    tx_data = {3'd5, 29'h55};
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("bad_addr_no_write", 64'(core_tx_valid), 64'd0);
    chk("bad_addr_no_drop", 64'(drop_count), 64'd64);
    // fill RX, almost-full at 12, full at 16
    for (int i = 0; i < 16; i++) begin
      core_rx_data = 29'(200 + i);
      core_rx_valid = 1'b1;
      step();
      chk($sformatf("rx_af_%0d", i + 1), 64'(rx_almost_full), 64'(i >= 11));
    end
    chk("rx_full", 64'(rx_full), 64'd1);
    chk("core_rx_full", 64'(core_rx_full), 64'd1);
    chk("rx_head_200", 64'(rx_data), 64'({3'd3, 29'd200}));
    core_rx_data = 29'd999;
    rx_read = 1'b1;
    step();
    core_rx_valid = 1'b0;
    chk("rx_push_full_blocked_drop", 64'(drop_count), 64'd65);
    chk("rx_not_full_after_pop", 64'(rx_full), 64'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("rx_pop_%0d", i), 64'(rx_data), 64'({3'd3, 29'(200 + i)}));
      step();
    end
    rx_read = 1'b0;
    chk("rx_drained", 64'(rx_empty), 64'd1);
    // simultaneous push/pop at count 8
    for (int i = 0; i < 8; i++) begin
      core_rx_data = 29'(300 + i);
      core_rx_valid = 1'b1;
      step();
    end
    core_rx_data = 29'd400;
    rx_read = 1'b1;
    step();
    core_rx_valid = 1'b0;
    chk("rx_pp_not_af", 64'(rx_almost_full), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rx_pp_pop_%0d", i), 64'(rx_data), 64'({3'd3, (i < 7) ? 29'(301 + i) : 29'd400}));
      step();
    end
    rx_read = 1'b0;
    chk("rx_pp_count8_empty", 64'(rx_empty), 64'd1);
    // push with pop while empty
    core_rx_data = 29'd500;
    core_rx_valid = 1'b1;
    rx_read = 1'b1;
    step();
    core_rx_valid = 1'b0;
    rx_read = 1'b0;
    chk("rx_empty_pp_nonempty", 64'(rx_empty), 64'd0);
    chk("rx_empty_pp_head", 64'(rx_data), 64'({3'd3, 29'd500}));
    rx_read = 1'b1;
    step();
    rx_read = 1'b0;
    chk("rx_empty_pp_count1", 64'(rx_empty), 64'd1);
    // half-fill both then reset mid-transfer
    for (int i = 0; i < 8; i++) begin
      tx_data = {3'd3, 29'(600 + i)};
      tx_valid = 1'b1;
      core_rx_data = 29'(700 + i);
      core_rx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    core_rx_valid = 1'b0;
    chk("half_tx_valid", 64'(core_tx_valid), 64'd1);
    chk("half_rx_nonempty", 64'(rx_empty), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_flags", 64'(flags()), 64'(7'b0001000));
    chk("async_reset_drop", 64'(drop_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_data = {3'd3, 29'h1};
    tx_valid = 1'b1;
    core_rx_valid = 1'b1;
    repeat (62) step();
    chk("re_ready_early", 64'(ready), 64'd0);
    step();
    chk("re_ready_at_63", 64'(ready), 64'd1);
    chk("dual_drop_by_two", 64'(drop_count), 64'd126);
    chk("re_tx_empty", 64'(core_tx_valid), 64'd0);
    // fill both FIFOs, then coincident drops up to saturation
    for (int i = 0; i < 16; i++) begin
      tx_data = {3'd3, 29'(i)};
      core_rx_data = 29'(i);
      step();
    end
    chk("fill_no_drop", 64'(drop_count), 64'd126);
    repeat (64) step();
    chk("drop_254", 64'(drop_count), 64'd254);
    step();
    chk("drop_sat_255", 64'(drop_count), 64'd255);
    step();
    chk("drop_hold_255", 64'(drop_count), 64'd255);
    tx_valid = 1'b0;
    core_rx_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
